// File: rtl/prog_loader.sv
// Program-image loader: takes a length header then program words over valid/ready
// and assembles them into the flat frame array consumed by the scheduler.
module prog_loader #(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 16,
    parameter int CNT_W = 11
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   s_valid,
    input  logic [WIDTH-1:0]       s_data,
    output logic                   s_ready,
    input  logic                   abort,
    output logic [DEPTH*WIDTH-1:0] data_frames_out,
    output logic                   prog_loading,
    output logic                   busy,
    output logic                   err_len,
    output logic [CNT_W-1:0]       words_loaded
);

    typedef enum logic [1:0] {IDLE, LEN, LOAD, DONE} state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_len;
    logic [CNT_W-1:0] r_words;
    logic             r_err;
    logic             r_ready;
    logic             r_busy;
    logic             r_pulse;
    logic             w_xfer;
    logic             w_hdr_ok;
    logic             w_hdr_acc;
    logic             w_hdr_bad;
    logic             w_wr;
    logic             w_last;
    logic [31:0]      w_hdr;

    // abort overrides a coincident transfer, so the word is simply dropped
    assign w_xfer    = s_valid & r_ready & ~abort;
    assign w_hdr     = 32'(s_data);
    assign w_hdr_ok  = (w_hdr >= 32'd1) && (w_hdr <= 32'(DEPTH));
    assign w_hdr_acc = (r_state == LEN) & w_xfer & w_hdr_ok;
    assign w_hdr_bad = (r_state == LEN) & w_xfer & ~w_hdr_ok;
    assign w_wr      = (r_state == LOAD) & w_xfer;
    assign w_last    = (r_words == (r_len - CNT_W'(1)));

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: if (s_valid) w_state_next = LEN;
            LEN: begin
                if (abort)          w_state_next = IDLE;
                else if (w_hdr_acc) w_state_next = LOAD;
                else if (w_hdr_bad) w_state_next = IDLE;
            end
            LOAD: begin
                if (abort)                w_state_next = IDLE;
                else if (w_wr && w_last)  w_state_next = DONE;
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Handshake and status flags are registered decodes of the next state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
            r_pulse <= 1'b0;
            r_len   <= '0;
            r_words <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_ready <= (w_state_next == LEN) || (w_state_next == LOAD);
            r_busy  <= (w_state_next == LEN) || (w_state_next == LOAD);
            r_pulse <= (w_state_next == DONE);
            if (w_hdr_acc) begin
                r_len   <= s_data[CNT_W-1:0];
                r_words <= '0;
                r_err   <= 1'b0;
            end else begin
                if (w_hdr_bad) r_err   <= 1'b1;
                if (w_wr)      r_words <= r_words + CNT_W'(1);
            end
        end
    end

    // One register per frame: cleared by a legal header, written when addressed
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_frame
            logic [WIDTH-1:0] r_frame;
            logic             w_hit;

            assign w_hit = w_wr && (r_words == CNT_W'(gi));

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_frame <= '0;
                end else if (w_hdr_acc) begin
                    r_frame <= '0;
                end else if (w_hit) begin
                    r_frame <= s_data;
                end
            end

            assign data_frames_out[gi*WIDTH +: WIDTH] = r_frame;
        end
    endgenerate

    assign s_ready      = r_ready;
    assign busy         = r_busy;
    assign prog_loading = r_pulse;
    assign err_len      = r_err;
    assign words_loaded = r_words;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: drives header/word streams and checks frames,
// handshake, pulse timing, error and abort behaviour against a local frame model.
module tb_prog_loader;

    localparam int DEPTH = 1024;
    localparam int WIDTH = 16;
    localparam int CNT_W = 11;

    logic                   clk;
    logic                   reset;
    logic                   s_valid;
    logic [WIDTH-1:0]       s_data;
    logic                   s_ready;
    logic                   abort;
    logic [DEPTH*WIDTH-1:0] data_frames_out;
    logic                   prog_loading;
    logic                   busy;
    logic                   err_len;
    logic [CNT_W-1:0]       words_loaded;

    logic [WIDTH-1:0] exp_f [DEPTH];
    int n_cmp;
    int n_err;
    int pulses;
    int busy_cycles;

    prog_loader #(.DEPTH(DEPTH), .WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .reset           (reset),
        .s_valid         (s_valid),
        .s_data          (s_data),
        .s_ready         (s_ready),
        .abort           (abort),
        .data_frames_out (data_frames_out),
        .prog_loading    (prog_loading),
        .busy            (busy),
        .err_len         (err_len),
        .words_loaded    (words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (prog_loading) pulses++;
        if (busy) busy_cycles++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_frames(input string tag);
        for (int k = 0; k < DEPTH; k++)
            chk($sformatf("%s_frame%0d", tag, k), 32'(data_frames_out[k*WIDTH +: WIDTH]), 32'(exp_f[k]));
    endtask

    task automatic clear_model();
        for (int k = 0; k < DEPTH; k++) exp_f[k] = '0;
    endtask

    // Present one word, wait (bounded) for s_ready, transfer on the next edge; s_valid left high
    task automatic send(input logic [WIDTH-1:0] d, input int idle);
        int n;
        for (int i = 0; i < idle; i++) begin
            s_valid = 1'b0;
            @(posedge clk); #1;
        end
        s_valid = 1'b1;
        s_data  = d;
        n = 0;
        @(negedge clk);
        while (!s_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) chk("ready_timeout", 32'(s_ready), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic send_words(input int cnt, input int base, input bit rnd);
        for (int i = 0; i < cnt; i++) begin
            send(WIDTH'(base + i), rnd ? int'($urandom_range(0, 2)) : 0);
            exp_f[i] = WIDTH'(base + i);
        end
        s_valid = 1'b0;
    endtask

    task automatic done_check(input string tag, input int len);
        @(negedge clk);
        chk({tag, "_pulse"}, 32'(prog_loading), 32'd1);
        chk({tag, "_words"}, 32'(words_loaded), 32'(len));
        chk({tag, "_ready_done"}, 32'(s_ready), 32'd0);
        @(negedge clk);
        chk({tag, "_pulse_end"}, 32'(prog_loading), 32'd0);
        chk({tag, "_busy_end"}, 32'(busy), 32'd0);
    endtask

    initial begin
        n_cmp = 0; n_err = 0; pulses = 0; busy_cycles = 0;
        reset = 1'b0; s_valid = 1'b0; s_data = '0; abort = 1'b0;
        clear_model();

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(s_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pulse", 32'(prog_loading), 32'd0);
        chk("rst_err", 32'(err_len), 32'd0);
        chk("rst_words", 32'(words_loaded), 32'd0);
        check_frames("rst");
        reset = 1'b1;
        @(posedge clk); #1;
        $display("step reset: done");

        // Reset mid-load after 5 of 10 words
        send(16'd10, 0);
        send_words(5, 16'h5000, 1'b0);
        chk("mid_busy", 32'(busy), 32'd1);
        chk("mid_words", 32'(words_loaded), 32'd5);
        chk("mid_frame4", 32'(data_frames_out[4*WIDTH +: WIDTH]), 32'h5004);
        #2 reset = 1'b0;
        #1;
        clear_model();
        chk("arst_ready", 32'(s_ready), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_words", 32'(words_loaded), 32'd0);
        check_frames("arst");
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        chk("arst_no_pulse", 32'(pulses), 32'd0);
        send(16'd3, 0);
        send_words(3, 16'h3000, 1'b0);
        done_check("after_rst", 3);
        check_frames("after_rst");
        chk("after_rst_pulses", 32'(pulses), 32'd1);
        $display("step reset-mid-load: pulses=%0d", pulses);

        // Back-to-back 3-word image: busy for L+1 cycles, pulse on the following cycle
        busy_cycles = 0;
        clear_model();
        send(16'd3, 0);
        send(16'hA001, 0); exp_f[0] = 16'hA001;
        send(16'hA002, 0); exp_f[1] = 16'hA002;
        send(16'hA003, 0); exp_f[2] = 16'hA003;
        s_valid = 1'b0;
        done_check("b2b", 3);
        chk("b2b_busy_cycles", 32'(busy_cycles), 32'd4);
        check_frames("b2b");
        chk("b2b_pulses", 32'(pulses), 32'd2);
        $display("step back-to-back L=3: busy_cycles=%0d", busy_cycles);

        // Full image with random idle gaps
        clear_model();
        send(16'd1024, 0);
        send_words(DEPTH, 0, 1'b1);
        done_check("full", DEPTH);
        check_frames("full");
        chk("full_pulses", 32'(pulses), 32'd3);
        $display("step full L=1024: words_loaded=%0d", words_loaded);

        // Illegal headers
        send(16'd0, 0);
        s_valid = 1'b0;
        @(negedge clk);
        chk("hdr0_err", 32'(err_len), 32'd1);
        chk("hdr0_busy", 32'(busy), 32'd0);
        chk("hdr0_ready", 32'(s_ready), 32'd0);
        @(posedge clk); #1;
        send(16'd1025, 0);
        s_valid = 1'b0;
        @(negedge clk);
        chk("hdr1025_err", 32'(err_len), 32'd1);
        chk("hdr1025_busy", 32'(busy), 32'd0);
        chk("hdr1025_words", 32'(words_loaded), 32'd1024);
        check_frames("hdr_bad");
        chk("hdr_bad_pulses", 32'(pulses), 32'd3);
        @(posedge clk); #1;
        send(16'd2, 0);
        s_valid = 1'b0;
        clear_model();
        @(negedge clk);
        chk("hdr2_err_clr", 32'(err_len), 32'd0);
        chk("hdr2_busy", 32'(busy), 32'd1);
        chk("hdr2_words", 32'(words_loaded), 32'd0);
        check_frames("hdr2_clear");
        @(posedge clk); #1;
        send_words(2, 16'hB000, 1'b0);
        done_check("hdr2", 2);
        check_frames("hdr2");
        $display("step illegal headers: err_len=%0d", err_len);

        // Abort coinciding with the 4th word
        clear_model();
        send(16'd8, 0);
        send_words(3, 16'hC000, 1'b0);
        s_valid = 1'b1; s_data = 16'hC003; abort = 1'b1;
        @(negedge clk);
        chk("abort_ready", 32'(s_ready), 32'd1);
        @(posedge clk); #1;
        abort = 1'b0; s_valid = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ready_off", 32'(s_ready), 32'd0);
        chk("abort_pulse", 32'(prog_loading), 32'd0);
        chk("abort_words", 32'(words_loaded), 32'd3);
        chk("abort_err", 32'(err_len), 32'd0);
        check_frames("abort");
        @(negedge clk);
        chk("abort_pulses", 32'(pulses), 32'd4);
        $display("step abort: words_loaded=%0d", words_loaded);

        // 8-word image, then header 2 clears the stale tail
        @(posedge clk); #1;
        clear_model();
        send(16'd8, 0);
        send_words(8, 16'hD000, 1'b0);
        done_check("img8", 8);
        check_frames("img8");
        send(16'd2, 0);
        s_valid = 1'b0;
        clear_model();
        @(negedge clk);
        check_frames("reload_clear");
        @(posedge clk); #1;
        send_words(2, 16'hE000, 1'b0);
        done_check("reload", 2);
        check_frames("reload");
        chk("reload_pulses", 32'(pulses), 32'd6);
        $display("step reload L=2: pulses=%0d", pulses);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
